ser_sum_collect: RTL

- Receiving end of the 16-bit serial adder's output: captures the LSB-first serial sum bit stream and reassembles it into a parallel word.
- Launches a capture on the same cycle the adder's parallel-load `mode` pulse is given.
- Delivers the assembled word through a valid/ready handshake to downstream parallel logic (register file, compare unit).

---
 rtl/ser_sum_collect.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ser_sum_collect.sv
// Serial-to-parallel collector for the serial adder's LSB-first sum stream, with a valid/ready output.
// Optional macro SER_COLLECT_ZERO_EN adds an out_zero flag registered with out_data.
module ser_sum_collect #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overrun,
`ifdef SER_COLLECT_ZERO_EN
    output logic             out_zero,
`endif
    output logic [1:0]       dbg_state
);

    // Handshake: a word transfers on any rising edge where out_valid and out_ready are both 1;
    // out_valid never drops and out_data never changes until that transfer or a discarding start.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] data_q;
    logic             busy_q;
    logic             valid_q;
    logic             overrun_q;
`ifdef SER_COLLECT_ZERO_EN
    logic             zero_q;
`endif

    // New bits enter at the MSB so the first bit lands in bit 0 after WIDTH captures.
    assign shreg_d = {sin, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SER_COLLECT_ZERO_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // Restart of an unfinished word; nothing completed is lost.
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end else if (cnt_q == LAST) begin
                        shreg_q <= shreg_d;
                        data_q  <= shreg_d;
                        cnt_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
`ifdef SER_COLLECT_ZERO_EN
                        zero_q  <= (shreg_d == '0);
`endif
                    end else begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q   <= SHIFT;
                        cnt_q     <= '0;
                        shreg_q   <= '0;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        overrun_q <= !out_ready;
`ifdef SER_COLLECT_ZERO_EN
                        zero_q    <= 1'b0;
`endif
                    end else if (out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
`ifdef SER_COLLECT_ZERO_EN
                        zero_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
`ifdef SER_COLLECT_ZERO_EN
    assign out_zero  = zero_q;
`endif

endmodule
